// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
// Holds the fetch PC and offers it over a valid/ready handshake. It arbitrates
// prioritised redirects, supports stall and debug halt/resume, and turns an
// illegal target into a one-cycle trap that vectors to TRAP_VECTOR.
// Optional feature: define PC_BOUNDS_CHECK_EN to enable the [PC_MIN, PC_MAX]
// range check (cause 2). Without it only alignment is checked.
module pc_sequencer #(
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [DATA_WIDTH-1:0]  TRAP_VECTOR  = '0,
   parameter logic [DATA_WIDTH-1:0]  PC_MIN       = '0,
   parameter logic [DATA_WIDTH-1:0]  PC_MAX       = 'h100,
   parameter int unsigned            NUM_REDIRECT = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REDIRECT-1:0]              redirect_valid_i,
   input  logic [NUM_REDIRECT*DATA_WIDTH-1:0]   redirect_target_i,
   input  logic                                 stall_i,
   input  logic                                 halt_req_i,
   input  logic                                 resume_i,
   input  logic                                 fetch_ready_i,
   output logic                                 fetch_valid_o,
   output logic [DATA_WIDTH-1:0]                fetch_pc_o,
   output logic                                 trap_valid_o,
   output logic [1:0]                           trap_cause_o,
   output logic [DATA_WIDTH-1:0]                trap_pc_o,
   output logic                                 halted_o
);

   typedef enum logic [1:0] {BOOT, RUN, TRAP, HALT} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] trap_pc_q;
   logic [1:0]            trap_cause_q;
   logic                  trap_valid_q;
   logic                  halted_q;

   logic                  fire;
   logic                  redir_any;
   logic [DATA_WIDTH-1:0] redir_tgt;
   logic                  cand_vld_d;
   logic [DATA_WIDTH-1:0] cand_d;
   logic [1:0]            cause_d;
   logic                  trap_take;

   assign fetch_valid_o = (state_q == RUN) && !stall_i;
   assign fire          = fetch_valid_o && fetch_ready_i;

   // Priority pick: scanning downward leaves the lowest asserted channel last.
   always_comb begin
      redir_any = 1'b0;
      redir_tgt = '0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         if (redirect_valid_i[i]) begin
            redir_any = 1'b1;
            redir_tgt = redirect_target_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Candidate next PC and its legality; HALT only considers redirects.
   always_comb begin
      cand_vld_d = ((state_q == RUN) && (redir_any || fire)) ||
                   ((state_q == HALT) && redir_any);
      cand_d     = redir_any ? redir_tgt : pc_q + DATA_WIDTH'(4);
      cause_d    = 2'd0;
      if (cand_d[1:0] != 2'b00) begin
         cause_d = 2'd1;
      end
`ifdef PC_BOUNDS_CHECK_EN
      else if ((cand_d < PC_MIN) || (cand_d > PC_MAX)) begin
         cause_d = 2'd2;
      end
`endif
   end

`ifndef PC_BOUNDS_CHECK_EN
   // Bounds are intentionally ignored when the range check is compiled out.
   logic unused_bounds;
   assign unused_bounds = ^{PC_MIN, PC_MAX};
`endif

   assign trap_take = cand_vld_d && (cause_d != 2'd0);

   // Sequencer FSM: all outputs except fetch_valid are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_VECTOR;
         trap_pc_q    <= '0;
         trap_cause_q <= 2'd0;
         trap_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         trap_valid_q <= 1'b0;
         if (trap_take) begin
            // A trap wins over halt_req and resume in the same cycle.
            trap_pc_q    <= cand_d;
            trap_cause_q <= cause_d;
            pc_q         <= TRAP_VECTOR;
            trap_valid_q <= 1'b1;
            halted_q     <= 1'b0;
            state_q      <= TRAP;
         end else begin
            case (state_q)
               BOOT: state_q <= RUN;
               RUN: begin
                  if (cand_vld_d) pc_q <= cand_d;
                  if (halt_req_i) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end
               end
               TRAP: state_q <= RUN;
               HALT: begin
                  if (cand_vld_d) pc_q <= cand_d;
                  if (resume_i) begin
                     state_q  <= RUN;
                     halted_q <= 1'b0;
                  end
               end
               default: state_q <= BOOT;
            endcase
         end
      end
   end

`ifdef SIMULATION
   // Trace each trap as it is taken.
   always @(posedge clk) begin
      if (rst_n && trap_take)
         $display("pc_sequencer: trap cause=%0d addr=%h", cause_d, cand_d);
   end
`endif

   assign fetch_pc_o   = pc_q;
   assign trap_valid_o = trap_valid_q;
   assign trap_cause_o = trap_cause_q;
   assign trap_pc_o    = trap_pc_q;
   assign halted_o     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors with literal expectations, plus an
// abstract reference model compared against the DUT on every falling edge.
module tb_pc_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 2;
   localparam logic [31:0] RST_V = 32'h0;
   localparam logic [31:0] TRP_V = 32'h0;
   localparam logic [31:0] PMIN  = 32'h0;
   localparam logic [31:0] PMAX  = 32'h100;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NR-1:0]  rv;
   logic [NR*DW-1:0] rt;
   logic           stall, halt_req, resume, ready;
   logic           fv, tv, hl;
   logic [DW-1:0]  fpc, tpc;
   logic [1:0]     tcause;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(
      .DATA_WIDTH(DW), .RESET_VECTOR(RST_V), .TRAP_VECTOR(TRP_V),
      .PC_MIN(PMIN), .PC_MAX(PMAX), .NUM_REDIRECT(NR)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid_i(rv), .redirect_target_i(rt),
      .stall_i(stall), .halt_req_i(halt_req), .resume_i(resume),
      .fetch_ready_i(ready),
      .fetch_valid_o(fv), .fetch_pc_o(fpc),
      .trap_valid_o(tv), .trap_cause_o(tcause), .trap_pc_o(tpc),
      .halted_o(hl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 boot, 1 run, 2 trap, 3 halt
   int          m_mode;
   logic [31:0] m_pc, m_tpc;
   int          m_cause;

   function automatic int legal_cause(input logic [31:0] a);
      if (a % 4 != 0) return 1;
`ifdef PC_BOUNDS_CHECK_EN
      if (a < PMIN || a > PMAX) return 2;
`endif
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_pc = RST_V; m_tpc = 0; m_cause = 0;
      end else begin
         int          sel;
         logic [31:0] next;
         bit          have, firing;
         sel = -1;
         for (int i = NR - 1; i >= 0; i--) if (rv[i]) sel = i;
         firing = (m_mode == 1) && !stall && ready;
         have   = 1'b0;
         next   = 32'h0;
         if (sel >= 0 && (m_mode == 1 || m_mode == 3)) begin
            have = 1'b1; next = rt[sel*DW +: DW];
         end else if (firing) begin
            have = 1'b1; next = m_pc + 32'd4;
         end
         if (have && legal_cause(next) != 0) begin
            m_tpc = next; m_cause = legal_cause(next); m_pc = TRP_V; m_mode = 2;
         end else begin
            if (have) m_pc = next;
            if (m_mode == 0 || m_mode == 2) m_mode = 1;
            else if (m_mode == 1 && halt_req) m_mode = 3;
            else if (m_mode == 3 && resume) m_mode = 1;
         end
      end
   end

   // Compare DUT against model away from the active edge.
   always @(negedge clk) begin
      chk("m_fetch_valid", {31'd0, fv}, {31'd0, (m_mode == 1) && !stall});
      chk("m_fetch_pc", fpc, m_pc);
      chk("m_trap_valid", {31'd0, tv}, {31'd0, m_mode == 2});
      chk("m_trap_cause", {30'd0, tcause}, 32'(m_cause));
      chk("m_trap_pc", tpc, m_tpc);
      chk("m_halted", {31'd0, hl}, {31'd0, m_mode == 3});
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic redir(input int ch, input logic [31:0] t);
      rv = '0;
      rv[ch] = 1'b1;
      rt[ch*DW +: DW] = t;
   endtask

   logic [31:0] tgt_tab [8] = '{32'h0, 32'h10, 32'h42, 32'h100, 32'h104, 32'hFC, 32'h3, 32'h200};

   initial begin
      rst_n = 1'b0; rv = '0; rt = '0; stall = 0; halt_req = 0; resume = 0; ready = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_fetch_pc", fpc, 32'h0);
      chk("rst_fetch_valid", {31'd0, fv}, 32'd0);
      chk("rst_trap_valid", {31'd0, tv}, 32'd0);
      chk("rst_halted", {31'd0, hl}, 32'd0);
      rst_n = 1'b1;                         // this cycle is BOOT
      chk("boot_fetch_valid", {31'd0, fv}, 32'd0);
      tick(); chk("seq0_pc", fpc, 32'h0); chk("seq0_valid", {31'd0, fv}, 32'd1);
      tick(); chk("seq1_pc", fpc, 32'h4);
      tick(); chk("seq2_pc", fpc, 32'h8);

      // Priority: channel 0 wins.
      rv = 2'b11; rt = {32'h80, 32'h40};
      tick(); chk("prio_pc", fpc, 32'h40);
      // Channel 1 alone under stall.
      rv = 2'b10; stall = 1;
      tick(); chk("stall_redir_pc", fpc, 32'h80); chk("stall_valid", {31'd0, fv}, 32'd0);
      rv = '0; stall = 0;

      // Misaligned redirect.
      redir(0, 32'h42);
      tick();
      chk("mis_trap_valid", {31'd0, tv}, 32'd1);
      chk("mis_cause", {30'd0, tcause}, 32'd1);
      chk("mis_trap_pc", tpc, 32'h42);
      chk("mis_pc", fpc, TRP_V);
      rv = '0;
      tick();
      chk("mis_trap_clr", {31'd0, tv}, 32'd0);
      chk("mis_run_valid", {31'd0, fv}, 32'd1);
      chk("mis_cause_hold", {30'd0, tcause}, 32'd1);

      // Upper bound: 0x100 is legal, its increment is not when bounded.
      redir(0, 32'h100);
      tick(); chk("bound_pc", fpc, 32'h100);
      rv = '0;
      tick();
`ifdef PC_BOUNDS_CHECK_EN
      chk("oor_cause", {30'd0, tcause}, 32'd2);
      chk("oor_trap_pc", tpc, 32'h104);
`else
      chk("inc_pc", fpc, 32'h104);
      redir(0, 32'hFFFF_FFFC);
      tick(); chk("top_pc", fpc, 32'hFFFF_FFFC);
      rv = '0;
      tick(); chk("wrap_pc", fpc, 32'h0);
`endif
      tick();

      // Halt, redirect while halted, resume.
      halt_req = 1;
      tick(); chk("halt_halted", {31'd0, hl}, 32'd1); chk("halt_valid", {31'd0, fv}, 32'd0);
      halt_req = 0; redir(0, 32'h20);
      tick(); chk("halt_redir_pc", fpc, 32'h20); chk("halt_still", {31'd0, hl}, 32'd1);
      rv = '0; resume = 1;
      tick();
      chk("resume_halted", {31'd0, hl}, 32'd0);
      chk("resume_valid", {31'd0, fv}, 32'd1);
      chk("resume_pc", fpc, 32'h20);
      resume = 0;

      // Illegal redirect while halted traps.
      halt_req = 1; tick(); halt_req = 0;
      redir(1, 32'h7);
      tick(); chk("halt_trap", {31'd0, tv}, 32'd1); chk("halt_trap_hl", {31'd0, hl}, 32'd0);
      rv = '0; tick();

      // Trap beats simultaneous halt_req.
      redir(0, 32'h42); halt_req = 1;
      tick(); chk("trap_vs_halt", {31'd0, tv}, 32'd1);
      rv = '0; halt_req = 0;
      tick(); chk("trap_vs_halt_hl", {31'd0, hl}, 32'd0);

      // Mixed burst, checked by the model only.
      for (int n = 0; n < 300; n++) begin
         stall    = ($urandom_range(0, 3) == 0);
         ready    = ($urandom_range(0, 3) != 0);
         halt_req = ($urandom_range(0, 9) == 0);
         resume   = ($urandom_range(0, 3) == 0);
         rv       = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(1, 3)) : '0;
         rt       = {tgt_tab[$urandom_range(0, 7)], tgt_tab[$urandom_range(0, 7)]};
         tick();
      end
      stall = 0; ready = 1; halt_req = 0; resume = 0; rv = '0;
      tick(); tick();
      resume = 1; tick(); resume = 0;

      // Async reset during TRAP.
      redir(0, 32'h42);
      tick(); chk("pre_rst_trap", {31'd0, tv}, 32'd1);
      rv = '0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", fpc, RST_V);
      chk("mid_rst_trap_valid", {31'd0, tv}, 32'd0);
      chk("mid_rst_cause", {30'd0, tcause}, 32'd0);
      chk("mid_rst_valid", {31'd0, fv}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); chk("post_rst_pc", fpc, 32'h0);
      tick(); chk("post_rst_pc1", fpc, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the core's fetch stage. It holds the architectural fetch PC and offers it to instruction memory over a valid/ready handshake. It arbitrates among N prioritised redirect sources (branch, jump, flush), supports stall and debug halt/resume, and converts misaligned or out-of-range targets into a one-cycle trap that vectors to a fixed handler address instead of silently freezing the PC.

## Interface
- DATA_WIDTH, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0000, PC loaded on trap. Must be word-aligned and inside [PC_MIN, PC_MAX].
- PC_MIN, 32'h0000_0000, lowest legal PC (inclusive).
- PC_MAX, 32'h0000_0100, highest legal PC (inclusive).
- NUM_REDIRECT, 2, number of redirect channels. Channel 0 has the highest priority. Minimum 1.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  NUM_REDIRECT  per-channel redirect request.
- redirect_target  in  NUM_REDIRECT*DATA_WIDTH  per-channel target; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- stall  in  1  pipeline stall; suppresses fetch_valid.
- halt_req  in  1  debug halt request.
- resume  in  1  debug resume.
- fetch_ready  in  1  instruction memory accepts the request.
- fetch_valid  out  1  fetch_pc is a valid request.
- fetch_pc  out  DATA_WIDTH  current fetch PC (registered).
- trap_valid  out  1  one-cycle trap pulse.
- trap_cause  out  2  1 = misaligned, 2 = out of range, 0 = none.
- trap_pc  out  DATA_WIDTH  offending target address.
- halted  out  1  high in HALT state.

## Operation
- States: BOOT, RUN, TRAP, HALT.
- Reset values: state BOOT, fetch_pc = RESET_VECTOR, trap_pc = 0, trap_cause = 0, trap_valid = 0, fetch_valid = 0, halted = 0.
- BOOT → RUN unconditionally after one cycle.
- fetch_valid = (state == RUN) && !stall.
- fire = fetch_valid && fetch_ready.
- Candidate next PC in RUN, in priority order:
  - lowest-index asserted redirect_target (applied even when stall is high or fire is low; the current request is discarded);
  - otherwise fetch_pc + 4 if fire;
  - otherwise hold.
- Increment arithmetic is modulo 2^DATA_WIDTH, so 0xFFFF_FFFC + 4 wraps to 0.
- Legality check applies only to redirect targets and increments:
  - target[1:0] != 0 → cause 1;
  - otherwise target < PC_MIN or target > PC_MAX → cause 2 (only when the macro is defined).
- An illegal candidate is not loaded. Instead: trap_pc ← candidate, trap_cause ← cause, fetch_pc ← TRAP_VECTOR, state → TRAP.
- TRAP: trap_valid = 1, fetch_valid = 0, redirects ignored; → RUN next cycle. trap_cause and trap_pc hold until the next trap.
- RUN with halt_req: this cycle's PC update and fire complete normally, then state → HALT. A trap detected in the same cycle wins, and halt_req is ignored.
- HALT: halted = 1, fetch_valid = 0, PC holds.
  - Redirects are still applied and checked; an illegal one → TRAP.
  - resume → RUN. resume takes priority over a simultaneous halt_req.
- resume outside HALT, and halt_req outside RUN, are ignored.
- Handshake: while fetch_valid is high and no redirect is present, fetch_pc is stable until fire. fetch_valid may drop without fire because of stall, halt, or trap (fetch is speculative).
- Reset asserted mid-operation returns all state to reset values asynchronously.

## Timing
- Redirect sampled at edge N → fetch_pc = target in cycle N+1.
- Fire at edge N → fetch_pc + 4 in cycle N+1, giving back-to-back issue at one request per cycle.
- Illegal target at edge N → TRAP in cycle N+1 (trap_valid high, fetch_pc = TRAP_VECTOR) → fetch_valid high in cycle N+2.
- First fetch_valid occurs in the second cycle after rst_n deasserts (BOOT occupies the first).
- fetch_valid is combinational from stall; all other outputs are registered.

## Configuration
- PC_BOUNDS_CHECK_EN:
  - Defined: the range check (cause 2) is active.
  - Undefined: only the alignment check runs; PC_MIN and PC_MAX are unused, and wrap past the top of the address space is legal.
- Under SIMULATION, each trap prints cause and address through $display.

## Test plan
- Reset release with stall = 0 and fetch_ready = 1 → fetch_pc 0x0, 0x4, 0x8 on consecutive cycles starting in the second cycle after reset.
- Channel 0 → 0x40 and channel 1 → 0x80 in the same cycle → next fetch_pc = 0x40. Channel 1 alone while stall = 1 → fetch_pc = 0x80, fetch_valid = 0.
- Redirect to 0x42 → trap_valid for one cycle, trap_cause = 1, trap_pc = 0x42, fetch_pc = TRAP_VECTOR, then RUN.
- With the macro defined, increment from 0x100 on fire → trap_cause = 2, trap_pc = 0x104. With the macro undefined, fetch_pc = 0x104.
- halt_req in RUN → halted the next cycle and fetch_valid = 0. A redirect to 0x20 during HALT, then resume → fetch_valid high with fetch_pc = 0x20.
- rst_n pulsed low during TRAP → immediately BOOT state, fetch_pc = RESET_VECTOR, trap_valid = 0.
